// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control unit.
//   - opcode constants (instruction bits [23:18])
//   - FSM state enumeration (4-bit, exported on the State debug port)
//   - ALUSrcB, AluOp and PCSource encodings
//   - ctrl_t: bundle of all datapath controls produced by the output decoder
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        ADDR      = 4'd3,
        EXEC_BEQ  = 4'd4,
        EXEC_ADDI = 4'd5,
        JUMP      = 4'd6,
        MEM_RD    = 4'd7,
        MEM_WR    = 4'd8,
        WB_R      = 4'd9,
        WB_MEM    = 4'd10,
        WB_ADDI   = 4'd11,
        TRAP      = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADDI  = 2'b11
    } aluOp_t;

    typedef enum logic [1:0] {
        SRCB_REG = 2'b00,
        SRCB_ONE = 2'b01,
        SRCB_IMM = 2'b10
    } aluSrcB_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcSource_t;

    typedef struct packed {
        logic      pcWrite;
        logic      pcWriteCond;
        logic      iorD;
        logic      irWrite;
        logic      memRead;
        logic      memWrite;
        logic      memToReg;
        logic      regDst;
        logic      regWrite;
        logic      aluSrcA;
        aluSrcB_t  aluSrcB;
        aluOp_t    aluOp;
        pcSource_t pcSource;
    } ctrl_t;

endpackage

// File: rtl/multicycle_cu_if.sv
// Bus between the multicycle control unit and its datapath.
//   master : datapath side (drives OPCODE/Zero/MemReady, receives controls)
//   slave  : control unit side
// Illegal exists only when MULTICYCLE_CU_TRAP_EN is defined.
interface multicycle_cu_if;

    logic [5:0] OPCODE;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] AluOp;
    logic [1:0] PCSource;
    logic [3:0] State;
`ifdef MULTICYCLE_CU_TRAP_EN
    logic       Illegal;

    modport master (
        output OPCODE, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, State, Illegal
    );

    modport slave (
        input  OPCODE, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, State, Illegal
    );
`else
    modport master (
        output OPCODE, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, State
    );

    modport slave (
        input  OPCODE, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, State
    );
`endif

endinterface

// File: rtl/mc_cu_decode.sv
// Moore output decoder for the multicycle control unit.
// Ports:
//   state    in   current FSM state
//   memReady in   gates IRWrite/PCWrite in FETCH
//   zero     in   gates the PC write in EXEC_BEQ
//   ctrl     out  all datapath controls
//   illegal  out  high in TRAP (only with MULTICYCLE_CU_TRAP_EN)
module mc_cu_decode
    import cpu_pkg::*;
(
    input  state_t state,
    input  logic   memReady,
    input  logic   zero,
`ifdef MULTICYCLE_CU_TRAP_EN
    output logic   illegal,
`endif
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
`ifdef MULTICYCLE_CU_TRAP_EN
        illegal = 1'b0;
`endif
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_ONE;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            DECODE: begin
                ctrl.aluSrcB  = SRCB_IMM;
            end
            EXEC_R: begin
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluOp    = ALUOP_FUNCT;
            end
            ADDR: begin
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluSrcB  = SRCB_IMM;
            end
            EXEC_BEQ: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
                // Branch resolved here so the datapath sees a ready-made PC write.
                ctrl.pcWrite     = zero;
            end
            EXEC_ADDI: begin
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluSrcB  = SRCB_IMM;
                ctrl.aluOp    = ALUOP_ADDI;
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            MEM_RD: begin
                ctrl.memRead  = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            MEM_WR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            WB_R: begin
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            WB_MEM: begin
                ctrl.memToReg = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            WB_ADDI: begin
                ctrl.regWrite = 1'b1;
            end
            TRAP: begin
`ifdef MULTICYCLE_CU_TRAP_EN
                illegal = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle CPU control unit: state register and next-state logic.
// Output decoding lives in mc_cu_decode.
// Ports:
//   Clock  in  system clock, rising edge
//   Reset  in  asynchronous active-high reset; forces FETCH, all controls 0
//   bus    multicycle_cu_if.slave (OPCODE/Zero/MemReady in, controls/State out)
// Build option: MULTICYCLE_CU_TRAP_EN -- undefined opcodes park in TRAP with
// a sticky Illegal flag; otherwise they retire as a NOP back to FETCH.
module multicycle_cu (
    input  logic           Clock,
    input  logic           Reset,
    multicycle_cu_if.slave bus
);
    import cpu_pkg::*;

    state_t state;
    state_t nextState;
    ctrl_t  dec;
    ctrl_t  act;
`ifdef MULTICYCLE_CU_TRAP_EN
    logic   illegal;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH:     if (bus.MemReady) nextState = DECODE;
            DECODE: begin
                case (bus.OPCODE)
                    OP_RTYPE:     nextState = EXEC_R;
                    OP_LW, OP_SW: nextState = ADDR;
                    OP_BEQ:       nextState = EXEC_BEQ;
                    OP_ADDI:      nextState = EXEC_ADDI;
                    OP_J:         nextState = JUMP;
`ifdef MULTICYCLE_CU_TRAP_EN
                    default:      nextState = TRAP;
`else
                    default:      nextState = FETCH;
`endif
                endcase
            end
            EXEC_R:    nextState = WB_R;
            ADDR:      nextState = (bus.OPCODE == OP_SW) ? MEM_WR : MEM_RD;
            EXEC_BEQ:  nextState = FETCH;
            EXEC_ADDI: nextState = WB_ADDI;
            JUMP:      nextState = FETCH;
            MEM_RD:    if (bus.MemReady) nextState = WB_MEM;
            MEM_WR:    if (bus.MemReady) nextState = FETCH;
            WB_R:      nextState = FETCH;
            WB_MEM:    nextState = FETCH;
            WB_ADDI:   nextState = FETCH;
`ifdef MULTICYCLE_CU_TRAP_EN
            TRAP:      nextState = TRAP;
`else
            TRAP:      nextState = FETCH;
`endif
            default:   nextState = FETCH;
        endcase
    end

    mc_cu_decode uDecode (
        .state    (state),
        .memReady (bus.MemReady),
        .zero     (bus.Zero),
`ifdef MULTICYCLE_CU_TRAP_EN
        .illegal  (illegal),
`endif
        .ctrl     (dec)
    );

    // State is already FETCH during reset, but FETCH drives MemRead; gate
    // everything so the datapath sees a fully quiet bus while Reset is high.
    assign act = Reset ? '0 : dec;

    assign bus.PCWrite     = act.pcWrite;
    assign bus.PCWriteCond = act.pcWriteCond;
    assign bus.IorD        = act.iorD;
    assign bus.IRWrite     = act.irWrite;
    assign bus.MemRead     = act.memRead;
    assign bus.MemWrite    = act.memWrite;
    assign bus.MemToReg    = act.memToReg;
    assign bus.RegDst      = act.regDst;
    assign bus.RegWrite    = act.regWrite;
    assign bus.ALUSrcA     = act.aluSrcA;
    assign bus.ALUSrcB     = act.aluSrcB;
    assign bus.AluOp       = act.aluOp;
    assign bus.PCSource    = act.pcSource;
    assign bus.State       = state;
`ifdef MULTICYCLE_CU_TRAP_EN
    assign bus.Illegal     = illegal;
`endif

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 SHALL have ports as listed (name, direction, width, meaning):
REQ-002 Clock  in  1  single system clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 OPCODE  in  6  instruction bits [23:18] taken from the instruction register.
REQ-005 Zero  in  1  ALU zero flag; used only for BEQ.
REQ-006 MemReady  in  1  memory done this cycle; read data is valid in the same cycle.
REQ-007 PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
REQ-008 ALUSrcB  out  2  selects 00=reg B, 01=const 1, 10=sign-extended immediate.
REQ-009 AluOp  out  2  encoded 00=add, 01=sub, 10=funct, 11=addi.
REQ-010 PCSource  out  2  selects 00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 State  out  4  current FSM state, for debug.
REQ-012 Illegal  out  1  sticky illegal-opcode flag; exists only with the trap macro defined.

Function
REQ-013 SHALL be a Moore FSM; every output SHALL be decoded from State only, except the MemReady/Zero gating given below.
REQ-014 SHALL use states FETCH, DECODE, EXEC_R, ADDR, EXEC_BEQ, EXEC_ADDI, JUMP, MEM_RD, MEM_WR, WB_R, WB_MEM, WB_ADDI, TRAP.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSource=00; IRWrite and PCWrite =MemReady; stays in FETCH until MemReady=1, then goes to DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=10, AluOp=00 (branch target); next state by opcode: 000000->EXEC_R, 100011/101011->ADDR, 000100->EXEC_BEQ, 001000->EXEC_ADDI, 000010->JUMP.
REQ-017 EXEC_R: ALUSrcA=1, ALUSrcB=00, AluOp=10 -> WB_R; WB_R: RegDst=1, RegWrite=1, MemToReg=0 -> FETCH.
REQ-018 ADDR: ALUSrcA=1, ALUSrcB=10, AluOp=00 -> MEM_RD for LW, MEM_WR for SW.
REQ-019 MEM_RD: MemRead=1, IorD=1; holds until MemReady -> WB_MEM; WB_MEM: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
REQ-020 MEM_WR: MemWrite=1, IorD=1; holds until MemReady -> FETCH.
REQ-021 EXEC_BEQ: ALUSrcA=1, ALUSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01; effective PC write =Zero -> FETCH.
REQ-022 EXEC_ADDI: ALUSrcA=1, ALUSrcB=10, AluOp=11 -> WB_ADDI; WB_ADDI: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10 -> FETCH.
REQ-024 Zero-wait latency SHALL be, in cycles: R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3; each cycle MemReady=0 SHALL add one cycle in FETCH, MEM_RD or MEM_WR.
REQ-025 Any output not listed for a state SHALL be 0; no X outputs are allowed.
REQ-026 MemRead and MemWrite SHALL never be asserted in the same cycle; RegWrite and MemWrite SHALL never be asserted in the same cycle.

Reset
REQ-027 Reset SHALL force State=FETCH and Illegal=0 asynchronously.
REQ-028 While Reset=1, all control outputs SHALL be 0.
REQ-029 Reset released mid-instruction SHALL restart at FETCH with no register write or memory write pending.

Configuration
REQ-030 With MULTICYCLE_CU_TRAP_EN defined: an undefined opcode in DECODE SHALL go to TRAP; TRAP holds forever with all controls 0 and Illegal=1 until Reset.
REQ-031 With MULTICYCLE_CU_TRAP_EN undefined: an undefined opcode SHALL go DECODE->FETCH (NOP, 3 cycles), the Illegal port SHALL be absent, and the TRAP state SHALL be unreachable.

Structure
REQ-032 Opcode constants, the state enumeration, and the AluOp, ALUSrcB and PCSource encodings SHALL live in shared package cpu_pkg.
REQ-033 Output decoding SHALL be one combinational sub-module, mc_cu_decode (State in, controls out); the FSM register and next-state logic SHALL stay in multicycle_cu.

Verification
REQ-034 R-type, MemReady tied 1 -> States FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 only in cycle 4.
REQ-035 LW with MemReady low for 3 cycles in MEM_RD -> 8 cycles total; MemToReg=1 and RegWrite=1 only in WB_MEM.
REQ-036 BEQ with Zero=1 and then with Zero=0 -> PCWriteCond=1 in cycle 3 both times; PC updated only when Zero=1.
REQ-037 Opcode 111111 -> TRAP with Illegal=1 held for 100 cycles (TRAP_EN), or back in FETCH at cycle 3 (no TRAP_EN).
REQ-038 Reset asserted in MEM_WR -> MemWrite=0 immediately, State=FETCH; first fetch after release is correct.
REQ-039 Random opcode/MemReady stream of 10k cycles -> the REQ-026 exclusions hold and no output is ever X.
